// File: rtl/grf_wr_arbiter.sv
// grf_wr_arbiter: shares the single GRF write port between two writeback requesters
//   (req0 = main datapath, req1 = long-latency unit) with round-robin arbitration,
//   a one-cycle registered write stage and a per-register pending-write scoreboard.
// Ports:
//   CLK, Reset           clock and synchronous active-high reset
//   reqN_valid/ready     handshake per requester; ready is combinational from valids
//   reqN_addr/data/pc    write request fields, held stable by requester until accepted
//   rf_we/a3/wd/pc       registered GRF write port, one cycle after acceptance
//   sb_set, sb_set_addr  allocate a pending write at decode
//   q1/q2_addr, busy     read-port queries against the pending counters
//   sb_err               sticky counter over/underflow flag
module grf_wr_arbiter #(
  parameter int NREQ_W = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  input  logic [31:0] req0_pc,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  input  logic [31:0] req1_pc,
  output logic        rf_we,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd,
  output logic [31:0] rf_pc,
  input  logic        sb_set,
  input  logic [4:0]  sb_set_addr,
  input  logic [4:0]  q1_addr,
  input  logic [4:0]  q2_addr,
  output logic        q1_busy,
  output logic        q2_busy,
  output logic        sb_err
);

  localparam logic [NREQ_W-1:0] CNT_MAX = '1;
  localparam logic [NREQ_W-1:0] CNT_ONE = NREQ_W'(1);

  logic              last_grant_q;
  logic              rf_we_q;
  logic [4:0]        rf_a3_q;
  logic [31:0]       rf_wd_q;
  logic [31:0]       rf_pc_q;
  logic [NREQ_W-1:0] cnt_q [32];
  logic [NREQ_W-1:0] cnt_d [32];
  logic              err_q;
  logic              err_d;

  logic        gnt0;
  logic        gnt1;
  logic        xfer;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;
  logic [31:0] sel_pc;
  logic [31:0] inc_v;
  logic [31:0] dec_v;

  // Under contention the requester that did not win last time is served;
  // last_grant resets to 1 so req0 wins the first contention.
  assign gnt0 = req0_valid & (~req1_valid | last_grant_q);
  assign gnt1 = req1_valid & (~req0_valid | ~last_grant_q);
  assign xfer = gnt0 | gnt1;

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign sel_addr = gnt1 ? req1_addr : req0_addr;
  assign sel_data = gnt1 ? req1_data : req0_data;
  assign sel_pc   = gnt1 ? req1_pc   : req0_pc;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      last_grant_q <= 1'b1;
      rf_we_q      <= 1'b0;
      rf_a3_q      <= '0;
      rf_wd_q      <= '0;
      rf_pc_q      <= '0;
    end else begin
      if (xfer) begin
        last_grant_q <= gnt1;
        rf_a3_q      <= sel_addr;
        rf_wd_q      <= sel_data;
        rf_pc_q      <= sel_pc;
      end
      // An addr=0 request consumes the grant but never writes.
      rf_we_q <= xfer && (sel_addr != 5'd0);
    end
  end

  assign rf_we = rf_we_q;
  assign rf_a3 = rf_a3_q;
  assign rf_wd = rf_wd_q;
  assign rf_pc = rf_pc_q;

  // One-hot per-register increment (allocation) and decrement (commit, not acceptance).
  assign inc_v = (sb_set && (sb_set_addr != 5'd0)) ? (32'd1 << sb_set_addr) : 32'd0;
  assign dec_v = rf_we_q ? (32'd1 << rf_a3_q) : 32'd0;

  always_comb begin
    err_d = err_q;
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    for (int r = 1; r < 32; r++) begin
      // Simultaneous increment and decrement cancel out.
      if (inc_v[r] && !dec_v[r]) begin
        if (cnt_q[r] == CNT_MAX) err_d = 1'b1;
        else                     cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (dec_v[r] && !inc_v[r]) begin
        if (cnt_q[r] == '0) err_d = 1'b1;
        else                cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      err_q <= err_d;
    end
  end

  // The commit cycle still reports busy; the counter drops on the following edge.
  assign q1_busy = (q1_addr != 5'd0) && (cnt_q[q1_addr] != '0);
  assign q2_busy = (q2_addr != 5'd0) && (cnt_q[q2_addr] != '0);
  assign sb_err  = err_q;

endmodule

// File: tb/tb_grf_wr_arbiter.sv
module tb_grf_wr_arbiter;

  localparam int CMAX = 3;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data, req0_pc, req1_pc;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd, rf_pc;
  logic        sb_set;
  logic [4:0]  sb_set_addr, q1_addr, q2_addr;
  logic        q1_busy, q2_busy, sb_err;

  grf_wr_arbiter #(.NREQ_W(2)) dut (
    .CLK(CLK), .Reset(Reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_data(req0_data), .req0_pc(req0_pc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_data(req1_data), .req1_pc(req1_pc),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .rf_pc(rf_pc),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr),
    .q1_addr(q1_addr), .q2_addr(q2_addr),
    .q1_busy(q1_busy), .q2_busy(q2_busy), .sb_err(sb_err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } wr_t;

  wr_t         expq[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Reference model state
  logic        m_last;
  logic        m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd, m_pc;
  int          m_cnt [32];
  logic        m_err;
  logic        g0, g1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic exp_busy(input logic [4:0] a);
    return (a != 5'd0) && (m_cnt[a] != 0);
  endfunction

  // Drive point is one unit after a rising edge; step checks the combinational
  // outputs, advances the model and compares the registered write stage.
  task automatic step();
    wr_t e;
    #1;
    g0 = req0_valid && (!req1_valid || m_last);
    g1 = req1_valid && (!req0_valid || !m_last);
    check_eq("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
    check_eq("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
    check_eq("q1_busy", {31'd0, q1_busy}, {31'd0, exp_busy(q1_addr)});
    check_eq("q2_busy", {31'd0, q2_busy}, {31'd0, exp_busy(q2_addr)});
    check_eq("sb_err", {31'd0, sb_err}, {31'd0, m_err});
    for (int r = 1; r < 32; r++) begin
      logic inc, dec;
      inc = sb_set && (sb_set_addr == 5'(r));
      dec = m_we && (m_a3 == 5'(r));
      if (inc && !dec) begin
        if (m_cnt[r] == CMAX) m_err = 1'b1; else m_cnt[r]++;
      end else if (dec && !inc) begin
        if (m_cnt[r] == 0) m_err = 1'b1; else m_cnt[r]--;
      end
    end
    if (g0 || g1) begin
      m_a3   = g1 ? req1_addr : req0_addr;
      m_wd   = g1 ? req1_data : req0_data;
      m_pc   = g1 ? req1_pc   : req0_pc;
      m_we   = (m_a3 != 5'd0);
      m_last = g1;
    end else begin
      m_we = 1'b0;
    end
    expq.push_back('{m_we, m_a3, m_wd, m_pc});
    @(posedge CLK);
    #1;
    e = expq.pop_front();
    check_eq("rf_we", {31'd0, rf_we}, {31'd0, e.we});
    check_eq("rf_a3", {27'd0, rf_a3}, {27'd0, e.a3});
    check_eq("rf_wd", rf_wd, e.wd);
    check_eq("rf_pc", rf_pc, e.pc);
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    sb_set     = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    Reset = 1'b1;
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    m_last = 1'b1;
    m_we   = 1'b0;
    m_a3   = '0;
    m_wd   = '0;
    m_pc   = '0;
    m_err  = 1'b0;
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    expq.delete();
    #1;
    check_eq("rst_rf_we", {31'd0, rf_we}, 32'd0);
    check_eq("rst_rf_a3", {27'd0, rf_a3}, 32'd0);
    check_eq("rst_rf_wd", rf_wd, 32'd0);
    check_eq("rst_rf_pc", rf_pc, 32'd0);
    check_eq("rst_q1_busy", {31'd0, q1_busy}, 32'd0);
    check_eq("rst_q2_busy", {31'd0, q2_busy}, 32'd0);
    check_eq("rst_sb_err", {31'd0, sb_err}, 32'd0);
  endtask

  task automatic drive0(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    req0_valid = 1'b1; req0_addr = a; req0_data = d; req0_pc = p;
  endtask

  task automatic drive1(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    req1_valid = 1'b1; req1_addr = a; req1_data = d; req1_pc = p;
  endtask

  initial begin
    Reset = 1'b1;
    req0_addr = '0; req0_data = '0; req0_pc = '0;
    req1_addr = '0; req1_data = '0; req1_pc = '0;
    sb_set_addr = '0; q1_addr = 5'd7; q2_addr = 5'd9;
    g0 = 1'b0; g1 = 1'b0;
    idle();
    do_reset();

    // Single request, one-cycle write latency, then idle.
    drive0(5'd5, 32'h1234, 32'h3000);
    step();
    idle();
    step();
    step();

    // Continuous contention from a fresh reset: grants alternate 0,1,0,1.
    do_reset();
    drive0(5'd3, 32'hA0, 32'h100);
    drive1(5'd4, 32'hB0, 32'h200);
    for (int i = 0; i < 4; i++) begin
      check_eq("contend_grant_pre", {31'd0, m_last}, {31'd0, i[0] == 1'b0});
      step();
    end
    idle();
    step();

    // Pending write on r7: busy through the commit cycle, clear after.
    do_reset();
    q1_addr = 5'd7;
    sb_set = 1'b1; sb_set_addr = 5'd7;
    step();
    sb_set = 1'b0;
    step();
    drive1(5'd7, 32'h77, 32'h700);
    step();
    idle();
    step();
    step();
    check_eq("q1_busy_after_commit", {31'd0, q1_busy}, 32'd0);

    // Same-cycle set and commit on r9 leaves the count at 1.
    q2_addr = 5'd9;
    sb_set = 1'b1; sb_set_addr = 5'd9;
    step();
    sb_set = 1'b0;
    drive0(5'd9, 32'h99, 32'h900);
    step();
    idle();
    sb_set = 1'b1; sb_set_addr = 5'd9;
    step();
    sb_set = 1'b0;
    step();
    check_eq("r9_still_busy", {31'd0, q2_busy}, 32'd1);
    check_eq("r9_no_err", {31'd0, sb_err}, 32'd0);

    // Overflow of r2 sets the sticky error.
    q1_addr = 5'd2;
    for (int i = 0; i < 4; i++) begin
      sb_set = 1'b1; sb_set_addr = 5'd2;
      step();
    end
    sb_set = 1'b0;
    step();
    check_eq("overflow_err", {31'd0, sb_err}, 32'd1);
    check_eq("overflow_busy", {31'd0, q1_busy}, 32'd1);

    // Underflow: commit to r1 with nothing allocated; error stays until reset.
    do_reset();
    drive0(5'd1, 32'h11, 32'h110);
    step();
    idle();
    step();
    step();
    step();
    check_eq("underflow_err_sticky", {31'd0, sb_err}, 32'd1);

    // addr=0 request consumes the grant without writing; req1 wins next contention.
    do_reset();
    drive0(5'd0, 32'hFFFF_FFFF, 32'h4000);
    step();
    check_eq("addr0_last_grant", {31'd0, m_last}, 32'd0);
    drive0(5'd10, 32'h1010, 32'h4004);
    drive1(5'd11, 32'h1111, 32'h4008);
    step();
    idle();
    step();

    // Randomised traffic, requesters hold fields until accepted.
    g0 = 1'b0; g1 = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (!req0_valid || g0) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_addr  = 5'($urandom_range(0, 31));
        req0_data  = $urandom;
        req0_pc    = $urandom;
      end
      if (!req1_valid || g1) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_addr  = 5'($urandom_range(0, 31));
        req1_data  = $urandom;
        req1_pc    = $urandom;
      end
      sb_set      = ($urandom_range(0, 2) == 0);
      sb_set_addr = 5'($urandom_range(0, 31));
      q1_addr     = 5'($urandom_range(0, 31));
      q2_addr     = 5'($urandom_range(0, 31));
      step();
    end
    idle();
    step();

    // Reset while a committed-write is registered but not yet seen by the GRF.
    do_reset();
    q1_addr = 5'd6; q2_addr = 5'd6;
    sb_set = 1'b1; sb_set_addr = 5'd6;
    step();
    sb_set = 1'b0;
    drive0(5'd6, 32'h66, 32'h600);
    step();
    check_eq("pending_we_before_rst", {31'd0, rf_we}, 32'd1);
    do_reset();
    check_eq("rst_drop_we", {31'd0, rf_we}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
